canny_linebuf3: RTL and testbench



---
 rtl/canny_linebuf3_if.sv | 24 ++
 rtl/canny_linebuf3.sv | 98 +++++++++
 tb/tb_canny_linebuf3.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/canny_linebuf3_if.sv
// canny_linebuf3_if: pixel-in / column-out stream bundle for the
// Canny three-row line buffer (core option macro: LB_REPLICATE_EN).
interface canny_linebuf3_if #(
   parameter int IW = 8,
   parameter int N  = 3
);
   logic          pix_vld;
   logic [IW-1:0] pix_in;
   logic          pix_sof;
   logic          col_vld;
   logic [N*IW-1:0] col_out;
   logic          col_sol;
   logic          col_eol;

   modport master (
      output pix_vld, pix_in, pix_sof,
      input  col_vld, col_out, col_sol, col_eol
   );

   modport slave (
      input  pix_vld, pix_in, pix_sof,
      output col_vld, col_out, col_sol, col_eol
   );
endinterface

// File: rtl/canny_linebuf3.sv
// canny_linebuf3: three-row line buffer feeding the 3x3 Sobel stage.
// Define LB_REPLICATE_EN to replicate row 0 into the top border rows.
module canny_linebuf3 #(
   parameter int IW    = 8,
   parameter int IMG_W = 640,
   parameter int AW    = 10,
   parameter int N     = 3
) (
   input  logic            clk,
   input  logic            rst_b,
   canny_linebuf3_if.slave bus,
   output logic            lb_err
);

   localparam logic [AW-1:0] X_LAST = AW'(IMG_W - 1);

   logic [IW-1:0] la [0:IMG_W-1];
   logic [IW-1:0] lb [0:IMG_W-1];

   logic [AW-1:0] x;
   logic [AW-1:0] x_eff;
   logic [AW-1:0] x_nxt;
   logic [1:0]    rcnt;
   logic [1:0]    r_eff;
   logic [1:0]    r_nxt;
   logic [IW-1:0] la_rd;
   logic [IW-1:0] lb_rd;
   logic [IW-1:0] mid;
   logic [IW-1:0] top;
   logic          row_ok;
   logic          acc;

   assign acc = bus.pix_vld;

   // Position of the incoming pixel, RAM reads and border selection.
   always_comb begin
      x_eff  = bus.pix_sof ? '0 : x;
      r_eff  = bus.pix_sof ? 2'd0 : rcnt;
      la_rd  = la[x_eff];
      lb_rd  = lb[x_eff];
      x_nxt  = (x_eff == X_LAST) ? '0 : x_eff + 1'b1;
      r_nxt  = r_eff;
      if (x_eff == X_LAST && r_eff != 2'd2)
         r_nxt = r_eff + 2'd1;
      mid    = la_rd;
      top    = lb_rd;
      row_ok = (r_eff == 2'd2);
`ifdef LB_REPLICATE_EN
      row_ok = 1'b1;
      if (r_eff == 2'd0) begin
         mid = bus.pix_in;
         top = bus.pix_in;
      end else if (r_eff == 2'd1) begin
         top = la_rd;
      end
`endif
   end

   // Line RAMs: shift row y-1 into row y-2, store the current pixel.
   always_ff @(posedge clk) begin
      if (acc) begin
         la[x_eff] <= bus.pix_in;
         lb[x_eff] <= la_rd;
      end
   end

   // Raster counters and the sticky mid-line start-of-frame flag.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         x      <= '0;
         rcnt   <= 2'd0;
         lb_err <= 1'b0;
      end else if (acc) begin
         x    <= x_nxt;
         rcnt <= r_nxt;
         if (bus.pix_sof && x != '0)
            lb_err <= 1'b1;
      end
   end

   // Output column register, one cycle behind the accepted pixel.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         bus.col_vld <= 1'b0;
         bus.col_out <= '0;
         bus.col_sol <= 1'b0;
         bus.col_eol <= 1'b0;
      end else begin
         bus.col_vld <= acc & row_ok;
         if (acc) begin
            bus.col_out <= (N*IW)'({bus.pix_in, mid, top});
            bus.col_sol <= (x_eff == '0);
            bus.col_eol <= (x_eff == X_LAST);
         end
      end
   end

endmodule

// File: tb/tb_canny_linebuf3.sv
// tb_canny_linebuf3: table-driven and randomized checks of the
// Canny three-row line buffer (honours LB_REPLICATE_EN).
module tb_canny_linebuf3;

   localparam int IW    = 8;
   localparam int IMG_W = 8;
   localparam int AW    = 3;
   localparam int N     = 3;
`ifdef LB_REPLICATE_EN
   localparam bit REP = 1'b1;
`else
   localparam bit REP = 1'b0;
`endif

   typedef struct {
      logic        v;
      logic [7:0]  p;
      logic        s;
      logic        ev;
      logic [23:0] eo;
      logic        esol;
      logic        eeol;
   } vec_t;

   logic clk = 1'b0;
   logic rst_b = 1'b0;
   logic lb_err;

   canny_linebuf3_if #(.IW(IW), .N(N)) bus ();

   canny_linebuf3 #(
      .IW(IW), .IMG_W(IMG_W), .AW(AW), .N(N)
   ) dut (
      .clk(clk),
      .rst_b(rst_b),
      .bus(bus),
      .lb_err(lb_err)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   int nvalid = 0;

   int mrow = 0;
   int mcol = 0;
   logic merr = 1'b0;
   logic [7:0] hist [3][IMG_W];
   logic [23:0] last_out = '0;
   logic last_sol = 1'b0;
   logic last_eol = 1'b0;
   logic last_ok = 1'b1;

   vec_t tbl [32];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mrow = 0;
      mcol = 0;
      merr = 1'b0;
      last_out = '0;
      last_sol = 1'b0;
      last_eol = 1'b0;
      last_ok = 1'b1;
   endtask

   task automatic drive(input logic v, input logic [7:0] p, input logic s);
      logic ev;
      logic [23:0] eo;
      logic esol;
      logic eeol;
      logic [7:0] r1;
      logic [7:0] r2;
      @(negedge clk);
      bus.pix_vld = v;
      bus.pix_in  = p;
      bus.pix_sof = s;
      ev = 1'b0;
      eo = last_out;
      esol = last_sol;
      eeol = last_eol;
      if (v) begin
         if (s) begin
            if (mcol != 0) merr = 1'b1;
            mcol = 0;
            mrow = 0;
         end
         hist[mrow % 3][mcol] = p;
         r1 = (mrow >= 1) ? hist[(mrow - 1) % 3][mcol] : p;
         r2 = (mrow >= 2) ? hist[(mrow - 2) % 3][mcol] : r1;
         eo = {p, r1, r2};
         esol = (mcol == 0);
         eeol = (mcol == IMG_W - 1);
         ev = REP ? 1'b1 : (mrow >= 2);
         mcol++;
         if (mcol == IMG_W) begin
            mcol = 0;
            mrow++;
         end
      end
      @(posedge clk);
      #1;
      chk("col_vld", 32'(bus.col_vld), 32'(ev));
      chk("lb_err", 32'(lb_err), 32'(merr));
      if (ev || (!v && last_ok)) begin
         chk("col_out", 32'(bus.col_out), 32'(eo));
         chk("col_sol", 32'(bus.col_sol), 32'(esol));
         chk("col_eol", 32'(bus.col_eol), 32'(eeol));
      end
      if (v) begin
         last_out = eo;
         last_sol = esol;
         last_eol = eeol;
         last_ok = ev;
      end
      if (bus.col_vld) nvalid++;
   endtask

   task automatic run(input int npix, input bit sof_first, input bit gaps);
      for (int i = 0; i < npix; i++) begin
         if (gaps) repeat ($urandom_range(0, 2)) drive(1'b0, 8'($urandom), 1'b0);
         drive(1'b1, 8'($urandom), sof_first && i == 0);
      end
   endtask

   task automatic async_reset();
      #2;
      bus.pix_vld = 1'b0;
      bus.pix_sof = 1'b0;
      rst_b = 1'b0;
      #1;
      chk("rst col_vld", 32'(bus.col_vld), 32'd0);
      chk("rst col_out", 32'(bus.col_out), 32'd0);
      chk("rst col_sol", 32'(bus.col_sol), 32'd0);
      chk("rst col_eol", 32'(bus.col_eol), 32'd0);
      chk("rst lb_err", 32'(lb_err), 32'd0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_b = 1'b1;
   endtask

   initial begin
      int exp_cols;
      bus.pix_vld = 1'b0;
      bus.pix_in  = '0;
      bus.pix_sof = 1'b0;
      exp_cols = REP ? 32 : 16;

      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < IMG_W; c++) begin
            int i;
            logic [7:0] p;
            i = r * IMG_W + c;
            p = 8'(16 * r + c);
            tbl[i].v = 1'b1;
            tbl[i].p = p;
            tbl[i].s = (i == 0);
            tbl[i].esol = (c == 0);
            tbl[i].eeol = (c == IMG_W - 1);
            tbl[i].ev = REP ? 1'b1 : (r >= 2);
            if (r == 0)
               tbl[i].eo = {p, p, p};
            else if (r == 1)
               tbl[i].eo = {p, p - 8'd16, p - 8'd16};
            else
               tbl[i].eo = {p, p - 8'd16, p - 8'd32};
         end
      end

      repeat (3) @(negedge clk);
      #1;
      chk("reset col_vld", 32'(bus.col_vld), 32'd0);
      chk("reset col_out", 32'(bus.col_out), 32'd0);
      chk("reset col_sol", 32'(bus.col_sol), 32'd0);
      chk("reset col_eol", 32'(bus.col_eol), 32'd0);
      chk("reset lb_err", 32'(lb_err), 32'd0);
      rst_b = 1'b1;

      nvalid = 0;
      for (int i = 0; i < 32; i++) begin
         drive(tbl[i].v, tbl[i].p, tbl[i].s);
         chk("tbl vld", 32'(bus.col_vld), 32'(tbl[i].ev));
         if (tbl[i].ev) begin
            chk("tbl out", 32'(bus.col_out), 32'(tbl[i].eo));
            chk("tbl sol", 32'(bus.col_sol), 32'(tbl[i].esol));
            chk("tbl eol", 32'(bus.col_eol), 32'(tbl[i].eeol));
         end
         if (i == 16) begin
            chk("first col", 32'(bus.col_out), 32'h201000);
            chk("first sol", 32'(bus.col_sol), 32'd1);
         end
         if (i == 31) begin
            chk("last col", 32'(bus.col_out), 32'h372717);
            chk("last eol", 32'(bus.col_eol), 32'd1);
         end
         if (REP && i == 0) chk("rep (0,0)", 32'(bus.col_out), 32'h000000);
         if (REP && i == 13) chk("rep (5,1)", 32'(bus.col_out), 32'h150505);
         if (!REP && i == 15) chk("row1 quiet", 32'(bus.col_vld), 32'd0);
      end
      chk("frame count", 32'(nvalid), 32'(exp_cols));

      nvalid = 0;
      for (int i = 0; i < 32; i++) begin
         repeat ($urandom_range(0, 2)) drive(1'b0, 8'($urandom), 1'b0);
         drive(1'b1, tbl[i].p, tbl[i].s);
      end
      chk("gap frame count", 32'(nvalid), 32'(exp_cols));

      nvalid = 0;
      run(4 * IMG_W, 1'b1, 1'b1);
      chk("frame2 count", 32'(nvalid), 32'(exp_cols));

      run(2 * IMG_W + 3, 1'b1, 1'b0);
      run(4 * IMG_W, 1'b1, 1'b1);
      chk("sof midline err", 32'(lb_err), 32'd1);
      run(10, 1'b0, 1'b1);
      chk("err sticky", 32'(lb_err), 32'd1);

      async_reset();
      run(3 * IMG_W + 4, 1'b1, 1'b0);
      async_reset();
      nvalid = 0;
      run(2 * IMG_W, 1'b0, 1'b1);
      chk("post-reset quiet", 32'(nvalid), REP ? 32'(2 * IMG_W) : 32'd0);
      run(IMG_W, 1'b0, 1'b1);
      run(5 * IMG_W, 1'b1, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
